gig_eth_mdio_master: RTL and testbench

Clause-22 MDIO management master that configures and polls the SGMII PHY and the PCS/PMA core's management registers over `mdc`/`mdio`. Accepts one read or write command at a time over a valid/ready handshake. Serialises each command into a 64-bit MDIO frame and returns read data with an error flag. Sits between the board-management logic and the tri-state `eth_mdio` pad (`mdio_o`/`mdio_t`/`mdio_i`).

---
 rtl/gig_eth_mdio_pkg.sv | 27 ++
 rtl/gig_eth_mdc_gen.sv | 38 +++
 rtl/gig_eth_mdio_master.sv | 133 +++++++++++++
 tb/tb_gig_eth_mdio_master.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gig_eth_mdio_pkg.sv
// Shared types and frame constants for the Clause-22 MDIO master.
package gig_eth_mdio_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPreamble,
    StHeader,
    StTurnaround,
    StData,
    StFinish
  } mdio_state_e;

  localparam logic [1:0] MDIO_ST    = 2'b01;
  localparam logic [1:0] MDIO_OP_WR = 2'b01;
  localparam logic [1:0] MDIO_OP_RD = 2'b10;

  localparam int unsigned MDIO_PREAMBLE_BITS = 32;
  localparam int unsigned MDIO_FRAME_BITS    = 64;

  // Header plus write turnaround packed into one 16-bit word for the TX shifter.
  function automatic logic [15:0] mdio_header(input logic       write,
                                              input logic [4:0] phyad,
                                              input logic [4:0] regad);
    return {MDIO_ST, (write ? MDIO_OP_WR : MDIO_OP_RD), phyad, regad, 2'b10};
  endfunction

endpackage

// File: rtl/gig_eth_mdc_gen.sv
// MDC divider: CLK_DIV cycles low then CLK_DIV cycles high while enabled.
module gig_eth_mdc_gen #(
  parameter int unsigned CLK_DIV = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic mdc,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int unsigned     CntW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q;
  logic            mdc_q;
  logic            wrap;

  assign wrap      = enable && (cnt_q == CntMax);
  // Strobes are high in the cycle before mdc changes, i.e. on the edge where it toggles.
  assign rise_tick = wrap && !mdc_q;
  assign fall_tick = wrap && mdc_q;
  assign mdc       = mdc_q;

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      cnt_q <= '0;
      mdc_q <= 1'b0;
    end else if (cnt_q == CntMax) begin
      cnt_q <= '0;
      mdc_q <= ~mdc_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/gig_eth_mdio_master.sv
// Clause-22 MDIO master: one read/write command per 64-bit frame over mdc/mdio.
module gig_eth_mdio_master
  import gig_eth_mdio_pkg::*;
#(
  parameter int unsigned CLK_DIV = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [4:0]  cmd_phyad,
  input  logic [4:0]  cmd_regad,
  input  logic [15:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_t,
  input  logic        mdio_i
);

  localparam logic [5:0] PreLast   = 6'(MDIO_PREAMBLE_BITS - 1);
  localparam logic [5:0] HdrLast   = 6'(MDIO_PREAMBLE_BITS + 13);
  localparam logic [5:0] TaLast    = 6'(MDIO_PREAMBLE_BITS + 15);
  localparam logic [5:0] FrameLast = 6'(MDIO_FRAME_BITS - 1);

  mdio_state_e state_q, state_d;
  logic [5:0]  bit_cnt_q;
  logic [15:0] tx_sr_q, rx_sr_q, wdata_q;
  logic        write_q, ta_err_q;
  logic        mdc_en, rise_tick, fall_tick, accept;

  assign accept = cmd_valid && cmd_ready;
  assign mdc_en = (state_q != StIdle) && (state_q != StFinish);

  gig_eth_mdc_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_mdc_gen (
    .clk       (clk),
    .reset     (reset),
    .enable    (mdc_en),
    .mdc       (mdc),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:       if (accept) state_d = StPreamble;
      StPreamble:   if (fall_tick && bit_cnt_q == PreLast) state_d = StHeader;
      StHeader:     if (fall_tick && bit_cnt_q == HdrLast) state_d = StTurnaround;
      StTurnaround: if (fall_tick && bit_cnt_q == TaLast) state_d = StData;
      StData:       if (fall_tick && bit_cnt_q == FrameLast) state_d = StFinish;
      StFinish:     state_d = StIdle;
      default:      state_d = StIdle;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == StIdle) && !reset;
    busy      = (state_q != StIdle);
    rsp_valid = (state_q == StFinish);
    mdio_o    = 1'b1;
    mdio_t    = 1'b1;
    unique case (state_q)
      StPreamble: begin
        mdio_t = 1'b0;
      end
      StHeader: begin
        mdio_t = 1'b0;
        mdio_o = tx_sr_q[15];
      end
      StTurnaround, StData: begin
        // Reads release the line so the PHY can drive turnaround and data.
        mdio_t = !write_q;
        mdio_o = write_q ? tx_sr_q[15] : 1'b1;
      end
      default: begin
        mdio_o = 1'b1;
        mdio_t = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      ta_err_q  <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state_q <= state_d;

      if (accept) begin
        write_q   <= cmd_write;
        wdata_q   <= cmd_wdata;
        tx_sr_q   <= mdio_header(cmd_write, cmd_phyad, cmd_regad);
        bit_cnt_q <= '0;
        ta_err_q  <= 1'b0;
      end

      if (rise_tick) begin
        if (state_q == StTurnaround && bit_cnt_q == TaLast) ta_err_q <= mdio_i;
        if (state_q == StData) rx_sr_q <= {rx_sr_q[14:0], mdio_i};
      end

      if (fall_tick) begin
        bit_cnt_q <= (bit_cnt_q == FrameLast) ? 6'd0 : bit_cnt_q + 6'd1;
        if (bit_cnt_q == TaLast) begin
          tx_sr_q <= wdata_q;
        end else if (state_q != StPreamble) begin
          tx_sr_q <= {tx_sr_q[14:0], 1'b0};
        end
      end

      // Publish the response on entry to FINISH so it is valid alongside rsp_valid.
      if (state_q == StData && state_d == StFinish) begin
        if (!write_q) rsp_rdata <= rx_sr_q;
        rsp_err <= !write_q && ta_err_q;
      end
    end
  end

endmodule

// File: tb/tb_gig_eth_mdio_master.sv
// Randomised bench for two MDIO masters (CLK_DIV 4 and 2) against a frame-level model.
module tb_gig_eth_mdio_master;

  localparam int NDUT = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic [NDUT-1:0] cmd_valid, cmd_write, mdio_i;
  logic [4:0]      cmd_phyad [NDUT];
  logic [4:0]      cmd_regad [NDUT];
  logic [15:0]     cmd_wdata [NDUT];
  wire  [NDUT-1:0] cmd_ready, rsp_valid, rsp_err, busy, mdc, mdio_o, mdio_t;
  wire  [15:0]     rsp_rdata [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    gig_eth_mdio_master #(
      .CLK_DIV ((g == 0) ? 4 : 2)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid[g]),
      .cmd_ready (cmd_ready[g]),
      .cmd_write (cmd_write[g]),
      .cmd_phyad (cmd_phyad[g]),
      .cmd_regad (cmd_regad[g]),
      .cmd_wdata (cmd_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g]),
      .busy      (busy[g]),
      .mdc       (mdc[g]),
      .mdio_o    (mdio_o[g]),
      .mdio_t    (mdio_t[g]),
      .mdio_i    (mdio_i[g])
    );
  end

  function automatic int div_of(input int d);
    return (d == 0) ? 4 : 2;
  endfunction

  int n_checks = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Frame monitor and PHY responder, evaluated away from the active edge.
  int          cyc = 0;
  int          rises    [NDUT];
  int          acc_cyc  [NDUT];
  int          acc_cnt  [NDUT];
  int          rsp_cyc  [NDUT];
  int          rsp_cnt  [NDUT];
  int          last_rise[NDUT];
  int          period   [NDUT];
  logic [63:0] cap_o    [NDUT];
  logic [63:0] cap_t    [NDUT];
  logic [NDUT-1:0] prev_mdc;
  logic [NDUT-1:0] phy_nophy = '0;
  logic [15:0] phy_data [NDUT];
  logic [15:0] mdl_rdata[NDUT];

  function automatic logic phy_bit(input int k, input logic nophy, input logic [15:0] data);
    if (nophy) return 1'b1;
    if (k == 47) return 1'b0;
    if (k >= 48 && k <= 63) return data[63-k];
    return 1'b1;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int d = 0; d < NDUT; d++) begin
      if (reset) begin
        rises[d] = 0;
      end else begin
        if (cmd_valid[d] && cmd_ready[d]) begin
          acc_cyc[d] = cyc;
          acc_cnt[d]++;
          rises[d] = 0;
          cap_o[d] = '0;
          cap_t[d] = '0;
        end
        if (mdc[d] && !prev_mdc[d]) begin
          if (rises[d] < 64) begin
            cap_o[d][63-rises[d]] = mdio_o[d];
            cap_t[d][63-rises[d]] = mdio_t[d];
          end
          period[d]    = cyc - last_rise[d];
          last_rise[d] = cyc;
          rises[d]++;
        end
        if (rsp_valid[d]) begin
          rsp_cyc[d] = cyc;
          rsp_cnt[d]++;
        end
      end
      mdio_i[d]   = phy_bit(rises[d], phy_nophy[d], phy_data[d]);
      prev_mdc[d] = mdc[d];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble(input int d);
    cmd_write[d] = 1'($urandom);
    cmd_phyad[d] = 5'($urandom);
    cmd_regad[d] = 5'($urandom);
    cmd_wdata[d] = 16'($urandom);
  endtask

  task automatic load_cmd(input int d, input logic w, input logic [4:0] phy,
                          input logic [4:0] rg, input logic [15:0] wd);
    cmd_write[d] = w;
    cmd_phyad[d] = phy;
    cmd_regad[d] = rg;
    cmd_wdata[d] = wd;
  endtask

  task automatic wait_rsp(input int d, input int n0, output bit ok);
    for (int i = 0; i < 140 * div_of(d) + 20 && rsp_cnt[d] == n0; i++) tick();
    ok = (rsp_cnt[d] != n0);
  endtask

  task automatic check_frame(input int d, input logic w, input logic nophy, input logic [4:0] phy,
                             input logic [4:0] rg, input logic [15:0] wd, input logic [15:0] rd);
    logic [63:0] exp_o, mask, exp_t;
    exp_o = {32'hFFFF_FFFF, 2'b01, (w ? 2'b01 : 2'b10), phy, rg, (w ? 2'b10 : 2'b00),
             (w ? wd : 16'h0000)};
    mask  = w ? {64{1'b1}} : {{46{1'b1}}, 18'h0};
    exp_t = w ? 64'h0 : 64'h3_FFFF;
    if (!w) mdl_rdata[d] = nophy ? 16'hFFFF : rd;
    check_eq("latency", rsp_cyc[d] - acc_cyc[d], 1 + 128 * div_of(d));
    check_eq("mdc_rises", rises[d], 64);
    check_eq("bit_period", period[d], 2 * div_of(d));
    check_eq("mdio_o_frame", cap_o[d] & mask, exp_o & mask);
    check_eq("mdio_t_frame", cap_t[d], exp_t);
    check_eq("rsp_rdata", rsp_rdata[d], mdl_rdata[d]);
    check_eq("rsp_err", rsp_err[d], !w && nophy);
    check_eq("rsp_pulse_end", rsp_valid[d], 0);
    check_eq("busy_end", busy[d], 0);
    check_eq("ready_after_rsp", cmd_ready[d], 1);
  endtask

  // One command with a stray cmd_valid burst mid-frame that must be ignored.
  task automatic do_txn(input int d, input logic w, input logic nophy, input logic [4:0] phy,
                        input logic [4:0] rg, input logic [15:0] wd, input logic [15:0] rd);
    int n0, a0;
    bit ok;
    phy_nophy[d] = nophy;
    phy_data[d]  = rd;
    for (int i = 0; i < 10 && !cmd_ready[d]; i++) tick();
    n0 = rsp_cnt[d];
    a0 = acc_cnt[d];
    load_cmd(d, w, phy, rg, wd);
    cmd_valid[d] = 1'b1;
    tick();
    cmd_valid[d] = 1'b0;
    check_eq("accept", acc_cnt[d] - a0, 1);
    check_eq("busy_start", busy[d], 1);
    repeat (40) begin
      scramble(d);
      tick();
    end
    cmd_valid[d] = 1'b1;
    repeat (5) tick();
    cmd_valid[d] = 1'b0;
    wait_rsp(d, n0, ok);
    check_eq("rsp_seen", ok, 1);
    if (ok) check_frame(d, w, nophy, phy, rg, wd, rd);
    check_eq("no_extra_accept", acc_cnt[d] - a0, 1);
    repeat (3) tick();
    check_eq("single_rsp", rsp_cnt[d] - n0, 1);
  endtask

  task automatic do_b2b(input int d);
    int n0, a0;
    bit ok;
    logic [15:0] wd_a, rd_b;
    logic [4:0]  phy_b, rg_b;
    wd_a  = 16'($urandom);
    rd_b  = 16'($urandom);
    phy_b = 5'($urandom);
    rg_b  = 5'($urandom);
    phy_nophy[d] = 1'b0;
    phy_data[d]  = rd_b;
    n0 = rsp_cnt[d];
    a0 = acc_cnt[d];
    load_cmd(d, 1'b1, 5'd3, 5'd4, wd_a);
    cmd_valid[d] = 1'b1;
    tick();
    load_cmd(d, 1'b0, phy_b, rg_b, 16'h0);
    wait_rsp(d, n0, ok);
    check_eq("b2b_rsp_a", ok, 1);
    if (ok) check_frame(d, 1'b1, 1'b0, 5'd3, 5'd4, wd_a, 16'h0);
    check_eq("b2b_held_valid_ignored", acc_cnt[d] - a0, 1);
    tick();
    cmd_valid[d] = 1'b0;
    check_eq("b2b_second_accept", acc_cnt[d] - a0, 2);
    check_eq("b2b_accept_gap", acc_cyc[d] - rsp_cyc[d], 1);
    scramble(d);
    wait_rsp(d, n0 + 1, ok);
    check_eq("b2b_rsp_b", ok, 1);
    if (ok) check_frame(d, 1'b0, 1'b0, phy_b, rg_b, 16'h0, rd_b);
  endtask

  task automatic do_abort();
    int n0;
    bit reached;
    phy_nophy[0] = 1'b0;
    phy_data[0]  = 16'hA5C3;
    n0 = rsp_cnt[0];
    load_cmd(0, 1'b0, 5'd9, 5'd2, 16'h0);
    cmd_valid[0] = 1'b1;
    tick();
    cmd_valid[0] = 1'b0;
    for (int i = 0; i < 600 && rises[0] < 41; i++) tick();
    reached = (rises[0] >= 41);
    check_eq("abort_reached_bit40", reached, 1);
    reset = 1'b1;
    tick();
    check_eq("abort_mdc", mdc[0], 0);
    check_eq("abort_mdio_t", mdio_t[0], 1);
    check_eq("abort_mdio_o", mdio_o[0], 1);
    check_eq("abort_busy", busy[0], 0);
    check_eq("abort_rsp_valid", rsp_valid[0], 0);
    check_eq("abort_ready_in_reset", cmd_ready[0], 0);
    check_eq("abort_rdata", rsp_rdata[0], 0);
    reset = 1'b0;
    for (int d = 0; d < NDUT; d++) mdl_rdata[d] = 16'h0;
    repeat (20) tick();
    check_eq("abort_no_rsp", rsp_cnt[0] - n0, 0);
    check_eq("abort_ready_after", cmd_ready[0], 1);
    do_txn(0, 1'b1, 1'b0, 5'd7, 5'd0, 16'hBEEF, 16'h0);
  endtask

  initial begin
    cmd_valid = '0;
    for (int d = 0; d < NDUT; d++) begin
      load_cmd(d, 1'b0, 5'd0, 5'd0, 16'h0);
      phy_data[d]  = 16'h0;
      mdl_rdata[d] = 16'h0;
    end
    repeat (3) tick();
    for (int d = 0; d < NDUT; d++) begin
      check_eq("rst_cmd_ready", cmd_ready[d], 0);
      check_eq("rst_busy", busy[d], 0);
      check_eq("rst_rsp_valid", rsp_valid[d], 0);
      check_eq("rst_rsp_rdata", rsp_rdata[d], 0);
      check_eq("rst_rsp_err", rsp_err[d], 0);
      check_eq("rst_mdc", mdc[d], 0);
      check_eq("rst_mdio_o", mdio_o[d], 1);
      check_eq("rst_mdio_t", mdio_t[d], 1);
    end
    reset = 1'b0;
    tick();
    check_eq("ready_after_reset", cmd_ready[0], 1);

    do_txn(0, 1'b1, 1'b0, 5'd7, 5'd0, 16'h1140, 16'h0);
    do_txn(0, 1'b0, 1'b0, 5'd7, 5'd1, 16'h0, 16'h796D);
    do_txn(0, 1'b0, 1'b1, 5'd7, 5'd1, 16'h0, 16'h0);
    do_b2b(0);
    do_abort();
    do_txn(1, 1'b1, 1'b0, 5'd1, 5'd4, 16'h01E1, 16'h0);
    do_txn(1, 1'b0, 1'b0, 5'd1, 5'd5, 16'h0, 16'h4DE1);

    for (int d = 0; d < NDUT; d++) begin
      for (int i = 0; i < 5; i++) begin
        logic w, np;
        w  = 1'($urandom);
        np = !w && ($urandom_range(0, 3) == 0);
        do_txn(d, w, np, 5'($urandom), 5'($urandom), 16'($urandom), 16'($urandom));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
